// File: rtl/bp_me_cfg_endpoint.sv
// bp_me_cfg_endpoint
// Per-tile config-bus slave sitting below the cfg boot loader. It decodes
// uncached read/write commands, owns the tile control registers
// (soft reset, freeze, cache/CCE modes, boot PC) and forwards CCE microcode
// accesses to the instruction RAM. Every command produces exactly one
// response, which the loader's credit counter depends on.
//
// Message layout (MSB..LSB):
//   { msg_type[3:0], size[2:0], payload[7:0], cce_id[5:0], addr[paddr_width_p-1:0], data[dword_width_p-1:0] }
//   Only addr[cfg_addr_width_p-1:0] takes part in decode.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   io_cmd_i/_v_i/_ready_o         command channel (transfer on v & ready)
//   io_resp_o/_v_o/_ready_i        response channel
//   reset_o, freeze_o              tile soft reset / freeze
//   icache_mode_o, dcache_mode_o   LCE modes (0 uncached, 1 normal, 2 nonspec)
//   cce_mode_o                     CCE mode (0 uncached, 1 normal)
//   npc_o                          boot PC
//   ucode_*                        microcode RAM request / read-data port
//
// States
//   state        | meaning
//   e_ready      | idle, accepting a command
//   e_ucode_req  | microcode request held until the RAM yumis it
//   e_ucode_wait | waiting for microcode read data
//   e_resp       | response presented until io_resp_ready_i
module bp_me_cfg_endpoint
    #(parameter int paddr_width_p                 = 40
    , parameter int cfg_addr_width_p              = 16
    , parameter int dword_width_p                 = 64
    , parameter int vaddr_width_p                 = 39
    , parameter int inst_width_p                  = 48
    , parameter int inst_ram_addr_width_p         = 8
    , parameter logic [vaddr_width_p-1:0] npc_reset_p = 39'h00_8000_0000
    , localparam int cce_mem_hdr_width_lp         = 4 + 3 + 8 + 6 + paddr_width_p
    , localparam int cce_mem_msg_width_lp         = cce_mem_hdr_width_lp + dword_width_p
    )
    (input  logic                             clk_i
    , input  logic                             reset_i

    , input  logic [cce_mem_msg_width_lp-1:0]  io_cmd_i
    , input  logic                             io_cmd_v_i
    , output logic                             io_cmd_ready_o

    , output logic [cce_mem_msg_width_lp-1:0]  io_resp_o
    , output logic                             io_resp_v_o
    , input  logic                             io_resp_ready_i

    , output logic                             reset_o
    , output logic                             freeze_o
    , output logic [1:0]                       icache_mode_o
    , output logic [1:0]                       dcache_mode_o
    , output logic                             cce_mode_o
    , output logic [vaddr_width_p-1:0]         npc_o

    , output logic                             ucode_v_o
    , output logic                             ucode_w_o
    , output logic [inst_ram_addr_width_p-1:0] ucode_addr_o
    , output logic [inst_width_p-1:0]          ucode_data_o
    , input  logic                             ucode_yumi_i
    , input  logic                             ucode_data_v_i
    , input  logic [inst_width_p-1:0]          ucode_data_i
    );

    localparam logic [3:0] e_uc_rd_lp = 4'd2;
    localparam logic [3:0] e_uc_wr_lp = 4'd3;

    localparam logic [cfg_addr_width_p-1:0] cfg_reg_reset_lp       = 'h0001;
    localparam logic [cfg_addr_width_p-1:0] cfg_reg_freeze_lp      = 'h0002;
    localparam logic [cfg_addr_width_p-1:0] cfg_reg_npc_lp         = 'h0003;
    localparam logic [cfg_addr_width_p-1:0] cfg_reg_icache_mode_lp = 'h0004;
    localparam logic [cfg_addr_width_p-1:0] cfg_reg_dcache_mode_lp = 'h0005;
    localparam logic [cfg_addr_width_p-1:0] cfg_reg_cce_mode_lp    = 'h0006;
    localparam logic [cfg_addr_width_p-1:0] cfg_mem_ucode_base_lp  = 'h8000;
    localparam logic [cfg_addr_width_p:0]   ucode_depth_lp =
        (cfg_addr_width_p+1)'(1) << inst_ram_addr_width_p;

    typedef enum logic [1:0] {
        e_ready,
        e_ucode_req,
        e_ucode_wait,
        e_resp
    } state_e;

    state_e state_q, state_d;

    logic [3:0]                      cmd_type;
    logic [cfg_addr_width_p-1:0]     cmd_addr;
    logic [dword_width_p-1:0]        cmd_data;
    logic [cce_mem_hdr_width_lp-1:0] cmd_hdr;
    logic [cfg_addr_width_p-1:0]     ucode_off;
    logic                            cmd_fire;
    logic                            cmd_is_wr;
    logic                            cmd_is_ucode;
    logic [dword_width_p-1:0]        reg_rdata;

    logic                             reset_q;
    logic                             freeze_q;
    logic [1:0]                       icache_mode_q;
    logic [1:0]                       dcache_mode_q;
    logic                             cce_mode_q;
    logic [vaddr_width_p-1:0]         npc_q;
    logic [cce_mem_hdr_width_lp-1:0]  hdr_q;
    logic [dword_width_p-1:0]         data_q;
    logic                             ucode_w_q;
    logic [inst_ram_addr_width_p-1:0] ucode_addr_q;
    logic [inst_width_p-1:0]          ucode_data_q;

    assign cmd_hdr   = io_cmd_i[cce_mem_msg_width_lp-1:dword_width_p];
    assign cmd_type  = io_cmd_i[cce_mem_msg_width_lp-1 -: 4];
    assign cmd_addr  = io_cmd_i[dword_width_p +: cfg_addr_width_p];
    assign cmd_data  = io_cmd_i[dword_width_p-1:0];
    assign cmd_fire  = io_cmd_v_i & io_cmd_ready_o;
    assign cmd_is_wr = (cmd_type == e_uc_wr_lp);

    // Subtraction wraps below the base, so the lower bound is checked separately.
    assign ucode_off    = cmd_addr - cfg_mem_ucode_base_lp;
    assign cmd_is_ucode = (cmd_addr >= cfg_mem_ucode_base_lp)
                        && ({1'b0, ucode_off} < ucode_depth_lp);

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_data[dword_width_p-1:inst_width_p],
                               ucode_off[cfg_addr_width_p-1:inst_ram_addr_width_p]};

    always_comb begin
        reg_rdata = '0;
        case (cmd_addr)
            cfg_reg_reset_lp:       reg_rdata[0]                 = reset_q;
            cfg_reg_freeze_lp:      reg_rdata[0]                 = freeze_q;
            cfg_reg_npc_lp:         reg_rdata[vaddr_width_p-1:0] = npc_q;
            cfg_reg_icache_mode_lp: reg_rdata[1:0]               = icache_mode_q;
            cfg_reg_dcache_mode_lp: reg_rdata[1:0]               = dcache_mode_q;
            cfg_reg_cce_mode_lp:    reg_rdata[0]                 = cce_mode_q;
            default:                reg_rdata                    = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_ready;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            e_ready:      if (cmd_fire)        state_d = cmd_is_ucode ? e_ucode_req : e_resp;
            e_ucode_req:  if (ucode_yumi_i)    state_d = ucode_w_q ? e_resp : e_ucode_wait;
            e_ucode_wait: if (ucode_data_v_i)  state_d = e_resp;
            e_resp:       if (io_resp_ready_i) state_d = e_ready;
            default:                           state_d = e_ready;
        endcase
    end

    always_comb begin
        io_cmd_ready_o = 1'b0;
        io_resp_v_o    = 1'b0;
        ucode_v_o      = 1'b0;
        case (state_q)
            e_ready:     io_cmd_ready_o = 1'b1;
            e_ucode_req: ucode_v_o      = 1'b1;
            e_resp:      io_resp_v_o    = 1'b1;
            default:     ;
        endcase
    end

    // Control registers; writes land on the same edge the command is accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            reset_q       <= 1'b1;
            freeze_q      <= 1'b1;
            icache_mode_q <= 2'd0;
            dcache_mode_q <= 2'd0;
            cce_mode_q    <= 1'b0;
            npc_q         <= npc_reset_p;
        end else if (cmd_fire && cmd_is_wr && !cmd_is_ucode) begin
            case (cmd_addr)
                cfg_reg_reset_lp:       reset_q       <= cmd_data[0];
                cfg_reg_freeze_lp:      freeze_q      <= cmd_data[0];
                cfg_reg_npc_lp:         npc_q         <= cmd_data[vaddr_width_p-1:0];
                cfg_reg_icache_mode_lp: icache_mode_q <= cmd_data[1:0];
                cfg_reg_dcache_mode_lp: dcache_mode_q <= cmd_data[1:0];
                cfg_reg_cce_mode_lp:    cce_mode_q    <= cmd_data[0];
                default:                ;
            endcase
        end
    end

    // Message and microcode request datapath. The ucode request fields are
    // loaded on every accepted command; they only matter in e_ucode_req.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_q        <= '0;
            data_q       <= '0;
            ucode_w_q    <= 1'b0;
            ucode_addr_q <= '0;
            ucode_data_q <= '0;
        end else if (cmd_fire) begin
            hdr_q        <= cmd_hdr;
            ucode_w_q    <= cmd_is_wr;
            ucode_addr_q <= ucode_off[inst_ram_addr_width_p-1:0];
            ucode_data_q <= cmd_data[inst_width_p-1:0];
            data_q       <= ((cmd_type == e_uc_rd_lp) && !cmd_is_ucode) ? reg_rdata : '0;
        end else if ((state_q == e_ucode_wait) && ucode_data_v_i) begin
            data_q <= (hdr_q[cce_mem_hdr_width_lp-1 -: 4] == e_uc_rd_lp)
                    ? {{(dword_width_p-inst_width_p){1'b0}}, ucode_data_i}
                    : '0;
        end
    end

    assign io_resp_o     = {hdr_q, data_q};
    assign reset_o       = reset_q;
    assign freeze_o      = freeze_q;
    assign icache_mode_o = icache_mode_q;
    assign dcache_mode_o = dcache_mode_q;
    assign cce_mode_o    = cce_mode_q;
    assign npc_o         = npc_q;
    assign ucode_w_o     = ucode_w_q;
    assign ucode_addr_o  = ucode_addr_q;
    assign ucode_data_o  = ucode_data_q;

endmodule
